// File: rtl/acc_store_port.sv
// Accumulator store port: snapshots the 16-bit accumulator on a store command
// and writes it to the byte-wide memory bus as two valid/ready beats.
// Optional build macro: ACC_STORE_PARITY_EN adds an even-parity output mem_wpar.
module acc_store_port #(
   parameter int LITTLE_ENDIAN = 1,
   parameter int TIMEOUT       = 255
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        st_req,
   input  logic [15:0] st_addr,
   input  logic [15:0] acc_in,
   output logic        st_busy,
   output logic        st_done,
   output logic        st_err,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
`ifdef ACC_STORE_PARITY_EN
   output logic        mem_wpar,
`endif
   output logic [1:0]  dbg_state
);

   // Memory handshake: a beat transfers on a rising CLK edge where
   // mem_valid && mem_ready; mem_valid/mem_addr/mem_wdata hold while stalled,
   // and mem_ready is ignored while mem_valid is low.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT0 = 2'd1,
      S_BEAT1 = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] base_q, base_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        mem_valid_q, mem_valid_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        st_busy_q, st_busy_d;
   logic        st_done_q, st_done_d;
   logic        st_err_q, st_err_d;
   logic        wpar_q, wpar_d;

   logic        hs;
   logic        stall;
   logic        tmo_hit;
   logic        accept;
   logic [7:0]  byte0;
   logic [7:0]  byte1;

   assign hs      = mem_valid_q && mem_ready;
   assign stall   = mem_valid_q && !mem_ready;
   assign tmo_hit = stall && (cnt_q == TMO_LAST);
   assign accept  = (state_q == S_IDLE) && st_req;

   // State register and registered outputs
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         base_q      <= '0;
         cnt_q       <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         st_busy_q   <= 1'b0;
         st_done_q   <= 1'b0;
         st_err_q    <= 1'b0;
         wpar_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         base_q      <= base_d;
         cnt_q       <= cnt_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         st_busy_q   <= st_busy_d;
         st_done_q   <= st_done_d;
         st_err_q    <= st_err_d;
         wpar_q      <= wpar_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (st_req) begin
               state_d = S_BEAT0;
               acc_d   = acc_in;
               base_d  = st_addr;
            end
         end
         S_BEAT0: begin
            if (hs) begin
               state_d = S_BEAT1;
            end else if (tmo_hit) begin
               state_d = S_DONE;
            end
         end
         S_BEAT1: begin
            if (hs || tmo_hit) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Counter restarts on every state change, so each beat gets a full budget
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (stall) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Output logic, computed from the next state so every output is a flop
   always_comb begin
      byte0       = (LITTLE_ENDIAN != 0) ? acc_d[7:0]  : acc_d[15:8];
      byte1       = (LITTLE_ENDIAN != 0) ? acc_d[15:8] : acc_d[7:0];
      mem_valid_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      st_busy_d   = (state_d != S_IDLE);
      st_done_d   = (state_d == S_DONE);
      st_err_d    = st_err_q;
      case (state_d)
         S_BEAT0: begin
            mem_valid_d = 1'b1;
            mem_addr_d  = base_d;
            mem_wdata_d = byte0;
         end
         S_BEAT1: begin
            mem_valid_d = 1'b1;
            mem_addr_d  = base_d + 16'd1;
            mem_wdata_d = byte1;
         end
         default: ;
      endcase
      if (accept) begin
         st_err_d = 1'b0;
      end else if (tmo_hit) begin
         st_err_d = 1'b1;
      end
      wpar_d = ^mem_wdata_d;
   end

   assign st_busy   = st_busy_q;
   assign st_done   = st_done_q;
   assign st_err    = st_err_q;
   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign dbg_state = state_q;

`ifdef ACC_STORE_PARITY_EN
   assign mem_wpar = wpar_q;
`else
   logic unused_wpar;
   assign unused_wpar = wpar_q;
`endif

endmodule

// File: tb/tb_acc_store_port.sv
// Directed bench for acc_store_port: one little-endian instance with a short
// timeout and one big-endian instance with the default timeout.
module tb_acc_store_port;

  logic        CLK;
  logic        reset_n;
  logic        st_req, st_req_be;
  logic [15:0] st_addr;
  logic [15:0] acc_in;
  logic        mem_ready;

  logic        le_busy, le_done, le_err, le_valid;
  logic [15:0] le_addr;
  logic [7:0]  le_wdata;
  logic [1:0]  le_state;
  logic        be_busy, be_done, be_err, be_valid;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic [1:0]  be_state;
`ifdef ACC_STORE_PARITY_EN
  logic        le_wpar, be_wpar;
`endif

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int hs_start;

  acc_store_port #(.LITTLE_ENDIAN(1), .TIMEOUT(4)) u_le (
    .CLK(CLK), .reset_n(reset_n), .st_req(st_req), .st_addr(st_addr),
    .acc_in(acc_in), .st_busy(le_busy), .st_done(le_done), .st_err(le_err),
    .mem_valid(le_valid), .mem_ready(mem_ready), .mem_addr(le_addr),
    .mem_wdata(le_wdata),
`ifdef ACC_STORE_PARITY_EN
    .mem_wpar(le_wpar),
`endif
    .dbg_state(le_state)
  );

  acc_store_port #(.LITTLE_ENDIAN(0), .TIMEOUT(255)) u_be (
    .CLK(CLK), .reset_n(reset_n), .st_req(st_req_be), .st_addr(st_addr),
    .acc_in(acc_in), .st_busy(be_busy), .st_done(be_done), .st_err(be_err),
    .mem_valid(be_valid), .mem_ready(mem_ready), .mem_addr(be_addr),
    .mem_wdata(be_wdata),
`ifdef ACC_STORE_PARITY_EN
    .mem_wpar(be_wpar),
`endif
    .dbg_state(be_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // handshake counter for the little-endian instance
  always @(posedge CLK) begin
    if (reset_n && le_valid && mem_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic le_beat(input string tag, input logic v, input logic [15:0] a, input logic [7:0] d);
    check({tag, ".valid"}, le_valid, v);
    check({tag, ".addr"}, le_addr, a);
    check({tag, ".data"}, le_wdata, d);
  endtask

  initial begin
    reset_n = 1'b0; st_req = 1'b0; st_req_be = 1'b0;
    st_addr = '0; acc_in = '0; mem_ready = 1'b0;
    tick();
    le_beat("rst", 1'b0, 16'h0000, 8'h00);
    check("rst.busy", le_busy, 1'b0);
    check("rst.done", le_done, 1'b0);
    check("rst.err", le_err, 1'b0);
    check("rst.state", le_state, 2'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: LE store, ready always high
    acc_in = 16'hBEEF; st_addr = 16'h0100; mem_ready = 1'b1; st_req = 1'b1;
    hs_start = hs_cnt;
    tick();
    st_req = 1'b0; acc_in = 16'h1234;
    le_beat("t1.b0", 1'b1, 16'h0100, 8'hEF);
    check("t1.busy", le_busy, 1'b1);
    tick();
    le_beat("t1.b1", 1'b1, 16'h0101, 8'hBE);
    check("t1.nodone", le_done, 1'b0);
    tick();
    le_beat("t1.dn", 1'b0, 16'h0000, 8'h00);
    check("t1.done", le_done, 1'b1);
    check("t1.busy_dn", le_busy, 1'b1);
    check("t1.err", le_err, 1'b0);
    tick();
    check("t1.done_off", le_done, 1'b0);
    check("t1.idle", le_busy, 1'b0);
    check("t1.hs", hs_cnt - hs_start, 2);

    // 2: BE instance, same stimulus
    acc_in = 16'hBEEF; st_addr = 16'h0100; st_req_be = 1'b1;
    tick();
    st_req_be = 1'b0;
    check("t2.b0.addr", be_addr, 16'h0100);
    check("t2.b0.data", be_wdata, 8'hBE);
    tick();
    check("t2.b1.addr", be_addr, 16'h0101);
    check("t2.b1.data", be_wdata, 8'hEF);
    tick();
    check("t2.done", be_done, 1'b1);
    tick();
    check("t2.idle", be_busy, 1'b0);

    // 3: three stalled cycles on beat0
    acc_in = 16'hA55A; st_addr = 16'h0200; mem_ready = 1'b0; st_req = 1'b1;
    hs_start = hs_cnt;
    tick();
    st_req = 1'b0;
    le_beat("t3.s0", 1'b1, 16'h0200, 8'h5A);
    tick();
    le_beat("t3.s1", 1'b1, 16'h0200, 8'h5A);
    tick();
    le_beat("t3.s2", 1'b1, 16'h0200, 8'h5A);
    tick();
    le_beat("t3.s3", 1'b1, 16'h0200, 8'h5A);
    check("t3.err_mid", le_err, 1'b0);
    mem_ready = 1'b1;
    tick();
    le_beat("t3.b1", 1'b1, 16'h0201, 8'hA5);
    tick();
    check("t3.done", le_done, 1'b1);
    check("t3.err", le_err, 1'b0);
    tick();
    check("t3.hs", hs_cnt - hs_start, 2);

    // 4: address wrap
    acc_in = 16'h1357; st_addr = 16'hFFFF; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    le_beat("t4.b0", 1'b1, 16'hFFFF, 8'h57);
    tick();
    le_beat("t4.b1", 1'b1, 16'h0000, 8'h13);
    tick();
    check("t4.done", le_done, 1'b1);
    tick();

    // 5: timeout (TIMEOUT=4) then recovery
    acc_in = 16'h0F0F; st_addr = 16'h0300; mem_ready = 1'b0; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    tick();
    tick();
    tick();
    le_beat("t5.stall4", 1'b1, 16'h0300, 8'h0F);
    tick();
    check("t5.valid_drop", le_valid, 1'b0);
    check("t5.err", le_err, 1'b1);
    check("t5.done", le_done, 1'b1);
    tick();
    check("t5.err_sticky", le_err, 1'b1);
    check("t5.idle", le_busy, 1'b0);
    mem_ready = 1'b1; acc_in = 16'h2468; st_addr = 16'h0310; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    check("t5.err_clr", le_err, 1'b0);
    le_beat("t5.r0", 1'b1, 16'h0310, 8'h68);
    tick();
    tick();
    check("t5.rdone", le_done, 1'b1);
    tick();

    // 6a: st_req during a store is ignored
    acc_in = 16'h0707; st_addr = 16'h0400; st_req = 1'b1;
    tick();
    acc_in = 16'hFFFF;
    tick();
    st_req = 1'b0;
    le_beat("t6.b1", 1'b1, 16'h0401, 8'h07);
`ifdef ACC_STORE_PARITY_EN
    check("t6.wpar", le_wpar, 1'b1);
`endif
    tick();
    check("t6.done", le_done, 1'b1);
    tick();
    tick();
    check("t6.no_queue", le_busy, 1'b0);
    check("t6.no_queue_v", le_valid, 1'b0);

    // 6b: reset during beat1
    acc_in = 16'h0707; st_addr = 16'h0500; mem_ready = 1'b1; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    tick();
    le_beat("t6r.b1", 1'b1, 16'h0501, 8'h07);
    reset_n = 1'b0;
    #1;
    le_beat("t6r.async", 1'b0, 16'h0000, 8'h00);
    check("t6r.busy", le_busy, 1'b0);
    check("t6r.state", le_state, 2'd0);
`ifdef ACC_STORE_PARITY_EN
    check("t6r.wpar", le_wpar, 1'b0);
`endif
    tick();
    check("t6r.nodone0", le_done, 1'b0);
    reset_n = 1'b1;
    tick();
    check("t6r.nodone1", le_done, 1'b0);
    check("t6r.idle", le_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
